adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_adder_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: four requesters share one N-bit adder through a round-robin
// arbiter. One operation is in flight at a time: IDLE grants and captures,
// CALC adds and registers the result and flags, and RESP holds the result
// until the consumer takes it.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b          : packed operands, requester k in [k*N +: N]
//   req_cin/req_signed   : per-requester carry-in and signed-mode select
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id               : requester that owns the presented result
//   rsp_sum              : (a + b + cin) mod 2^N
//   rsp_cout/neg/ovf/zero: result flags
//   op_count             : number of consumed responses (wraps)
module adder_arbiter #(
  parameter int unsigned N = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req_valid,
  output logic [3:0]     req_ready,
  input  logic [4*N-1:0] req_a,
  input  logic [4*N-1:0] req_b,
  input  logic [3:0]     req_cin,
  input  logic [3:0]     req_signed,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [1:0]     rsp_id,
  output logic [N-1:0]   rsp_sum,
  output logic           rsp_cout,
  output logic           rsp_neg,
  output logic           rsp_ovf,
  output logic           rsp_zero,
  output logic [31:0]    op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;

  // Operation captured at grant time
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          cin_q, cin_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    id_q, id_d;

  // Registered response
  logic [1:0]    rsp_id_q, rsp_id_d;
  logic [N-1:0]  rsp_sum_q, rsp_sum_d;
  logic          rsp_cout_q, rsp_cout_d;
  logic          rsp_neg_q, rsp_neg_d;
  logic          rsp_ovf_q, rsp_ovf_d;
  logic          rsp_zero_q, rsp_zero_d;
  logic [31:0]   op_count_q, op_count_d;

  logic          gnt_found;
  logic [1:0]    gnt_idx;
  logic [N:0]    add_full;

  // Round-robin search: first valid requester starting at ptr_q, wrapping mod 4.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = ptr_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!gnt_found && req_valid[ptr_q + 2'(i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ptr_q + 2'(i);
      end
    end
  end

  // The single shared adder; bit N is the carry-out.
  assign add_full = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    sgn_d      = sgn_q;
    id_d       = id_q;
    rsp_id_d   = rsp_id_q;
    rsp_sum_d  = rsp_sum_q;
    rsp_cout_d = rsp_cout_q;
    rsp_neg_d  = rsp_neg_q;
    rsp_ovf_d  = rsp_ovf_q;
    rsp_zero_d = rsp_zero_q;
    op_count_d = op_count_q;
    req_ready  = '0;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          a_d     = req_a[gnt_idx*N +: N];
          b_d     = req_b[gnt_idx*N +: N];
          cin_d   = req_cin[gnt_idx];
          sgn_d   = req_signed[gnt_idx];
          id_d    = gnt_idx;
          ptr_d   = gnt_idx + 2'd1;
          state_d = CALC;
        end
      end
      CALC: begin
        rsp_id_d   = id_q;
        rsp_sum_d  = add_full[N-1:0];
        rsp_cout_d = add_full[N];
        rsp_neg_d  = sgn_q & add_full[N-1];
        // Signed overflow: like-signed operands producing a differently signed sum.
        rsp_ovf_d  = sgn_q ? ((a_q[N-1] == b_q[N-1]) && (add_full[N-1] != a_q[N-1]))
                           : add_full[N];
        rsp_zero_d = (add_full[N-1:0] == '0);
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grants are suppressed while reset is applied; the registers below
    // discard anything captured in that cycle.
    if (rst) begin
      req_ready = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      sgn_q      <= 1'b0;
      id_q       <= '0;
      rsp_id_q   <= '0;
      rsp_sum_q  <= '0;
      rsp_cout_q <= 1'b0;
      rsp_neg_q  <= 1'b0;
      rsp_ovf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      sgn_q      <= sgn_d;
      id_q       <= id_d;
      rsp_id_q   <= rsp_id_d;
      rsp_sum_q  <= rsp_sum_d;
      rsp_cout_q <= rsp_cout_d;
      rsp_neg_q  <= rsp_neg_d;
      rsp_ovf_q  <= rsp_ovf_d;
      rsp_zero_q <= rsp_zero_d;
      op_count_q <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Testbench for adder_arbiter: directed cases plus randomized traffic, checked
// by a scoreboard queue filled at grant time and drained by a negedge monitor.
module tb_adder_arbiter;

  localparam int unsigned N = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [3:0]     req_valid = '0;
  logic [3:0]     req_ready;
  logic [4*N-1:0] req_a = '0;
  logic [4*N-1:0] req_b = '0;
  logic [3:0]     req_cin = '0;
  logic [3:0]     req_signed = '0;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_id;
  logic [N-1:0]   rsp_sum;
  logic           rsp_cout, rsp_neg, rsp_ovf, rsp_zero;
  logic [31:0]    op_count;

  adder_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_signed(req_signed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum),
    .rsp_cout(rsp_cout), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   id;
    logic [N-1:0] sum;
    logic [3:0]   flags;  // {cout, neg, ovf, zero}
    int           t;      // monitor cycle of the grant
  } exp_t;

  exp_t         sb[$];
  int           glog[$];
  int           gcyc[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           grants = 0;
  int           exp_count = 0;
  int           mptr = 0;
  logic         busy = 1'b0;
  logic         rst_prev = 1'b0;
  logic [3:0]   gnt_seen = '0;
  logic [N-1:0] last_sum = '0;
  logic [1:0]   last_id = '0;
  logic [3:0]   last_flags = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic: unsigned sum with carry, and the
  // signed sum checked against the representable N-bit range.
  function automatic exp_t model(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic cin, input logic sgn, input int t);
    exp_t                 e;
    logic [N:0]           u;
    logic signed [N+1:0]  s;
    logic signed [N+1:0]  maxs;
    logic signed [N+1:0]  mins;
    logic                 ovf;
    maxs = {3'b000, {(N-1){1'b1}}};
    mins = {3'b111, {(N-1){1'b0}}};
    u = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
    s = $signed({{2{a[N-1]}}, a}) + $signed({{2{b[N-1]}}, b}) + $signed({{(N+1){1'b0}}, cin});
    ovf = sgn ? ((s > maxs) || (s < mins)) : u[N];
    e.id    = 2'(id);
    e.sum   = u[N-1:0];
    e.flags = {u[N], sgn & u[N-1], ovf, (u[N-1:0] == '0)};
    e.t     = t;
    return e;
  endfunction

  // Monitor: predicts the grant from valid requests and pointer, and checks
  // responses against the scoreboard head.
  initial begin : monitor
    logic [3:0] er;
    logic       erv;
    int         k;
    int         gk;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_prev) begin
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_id",    128'(rsp_id),    128'(0));
        chk("rst_rsp_sum",   128'(rsp_sum),   128'(0));
        chk("rst_flags",     128'({rsp_cout, rsp_neg, rsp_ovf, rsp_zero}), 128'(0));
        chk("rst_op_count",  128'(op_count),  128'(0));
      end
      if (rst) begin
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        sb.delete();
        busy      = 1'b0;
        mptr      = 0;
        exp_count = 0;
        rst_prev  = 1'b1;
      end else begin
        rst_prev = 1'b0;
        chk("op_count", 128'(op_count), 128'(exp_count));
        er = '0;
        gk = 0;
        if (!busy) begin
          for (int i = 0; i < 4; i++) begin
            k = (mptr + i) % 4;
            if (er == 4'b0 && req_valid[k]) begin
              er[k] = 1'b1;
              gk    = k;
            end
          end
        end
        chk("req_ready", 128'(req_ready), 128'(er));
        if (er != 4'b0) begin
          sb.push_back(model(gk, req_a[gk*N +: N], req_b[gk*N +: N],
                             req_cin[gk], req_signed[gk], cyc));
          mptr         = (gk + 1) % 4;
          busy         = 1'b1;
          gnt_seen[gk] = 1'b1;
          grants++;
          glog.push_back(gk);
          gcyc.push_back(cyc);
        end
        erv = 1'b0;
        if (sb.size() > 0) begin
          if (cyc >= sb[0].t + 2) erv = 1'b1;
        end
        chk("rsp_valid", 128'(rsp_valid), 128'(erv));
        if (erv && rsp_valid) begin
          chk("rsp_id",    128'(rsp_id),  128'(sb[0].id));
          chk("rsp_sum",   128'(rsp_sum), 128'(sb[0].sum));
          chk("rsp_flags", 128'({rsp_cout, rsp_neg, rsp_ovf, rsp_zero}), 128'(sb[0].flags));
          if (rsp_ready) begin
            last_sum   = rsp_sum;
            last_id    = rsp_id;
            last_flags = {rsp_cout, rsp_neg, rsp_ovf, rsp_zero};
            void'(sb.pop_front());
            busy = 1'b0;
            exp_count++;
          end
        end
      end
    end
  end

  // Advance one cycle; drop req_valid for requesters granted in the cycle just ended.
  task automatic step();
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (gnt_seen[k]) begin
        req_valid[k] = 1'b0;
        gnt_seen[k]  = 1'b0;
      end
    end
  endtask

  task automatic post(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, input logic s);
    req_a[k*N +: N] = a;
    req_b[k*N +: N] = b;
    req_cin[k]      = c;
    req_signed[k]   = s;
    req_valid[k]    = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((req_valid != 4'b0 || busy || sb.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk("idle_timeout", 128'(n < 100), 128'(1));
  endtask

  function automatic logic [N-1:0] rnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(N-1){1'b1}}};
      3:       return {1'b1, {(N-1){1'b0}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  initial begin : driver
    int order[5] = '{0, 1, 2, 3, 0};
    int g0;
    bit reposted;

    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Stall a response for several cycles with another request waiting,
    // then reset it away while in RESP.
    rsp_ready = 1'b0;
    post(2, rnd(), rnd(), rbit(), rbit());
    repeat (3) step();
    post(0, rnd(), rnd(), rbit(), rbit());
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // All four requesting with rsp_ready high: grants 0,1,2,3,0 every 3 cycles.
    rsp_ready = 1'b1;
    g0 = grants;
    post(1, rnd(), rnd(), rbit(), rbit());
    post(2, rnd(), rnd(), rbit(), rbit());
    post(3, rnd(), rnd(), rbit(), rbit());
    reposted = 1'b0;
    for (int n = 0; n < 40; n++) begin
      step();
      if (!reposted && grants == g0 + 1) begin
        post(0, rnd(), rnd(), rbit(), rbit());
        reposted = 1'b1;
      end
      if (grants >= g0 + 5) break;
    end
    wait_idle();
    chk("grant_count", 128'(glog.size() - g0), 128'(5));
    if (glog.size() >= g0 + 5) begin
      for (int i = 0; i < 5; i++) chk("grant_order", 128'(glog[g0+i]), 128'(order[i]));
      for (int i = 1; i < 5; i++) chk("grant_interval", 128'(gcyc[g0+i] - gcyc[g0+i-1]), 128'(3));
    end
    chk("op_count_after_5", 128'(op_count), 128'(5));

    // 5 + 7 unsigned
    post(0, 64'd5, 64'd7, 1'b0, 1'b0);
    wait_idle();
    chk("basic_sum",   128'(last_sum),   128'(12));
    chk("basic_id",    128'(last_id),    128'(0));
    chk("basic_flags", 128'(last_flags), 128'(4'b0000));

    // Signed overflow at the positive limit, then the same operands unsigned.
    post(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    wait_idle();
    chk("sovf_sum",   128'(last_sum),   128'(64'h8000_0000_0000_0000));
    chk("sovf_id",    128'(last_id),    128'(2));
    chk("sovf_flags", 128'(last_flags), 128'(4'b0110));
    post(2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_idle();
    chk("uns_sum",   128'(last_sum),   128'(64'h8000_0000_0000_0000));
    chk("uns_flags", 128'(last_flags), 128'(4'b0000));

    // All-ones plus carry-in wraps to zero with carry.
    post(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0);
    wait_idle();
    chk("wrap_sum",   128'(last_sum),   128'(0));
    chk("wrap_id",    128'(last_id),    128'(1));
    chk("wrap_flags", 128'(last_flags), 128'(4'b1011));

    // Random traffic with back-pressure.
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!req_valid[k] && $urandom_range(0, 2) == 0)
          post(k, rnd(), rnd(), rbit(), rbit());
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rsp_ready = 1'b1;
    wait_idle();
    chk("final_op_count", 128'(op_count), 128'(exp_count));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
